pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage CPU. It merges stall and flush requests into one consistent set of per-stage controls:
- load-use stall from the hazard unit;
- taken branch/jump from EX;
- multi-cycle multiply/divide handshake;
- data-memory wait.

Outputs are PC/pipeline-register write enables and bubble (flush) controls. It sits beside the hazard unit and drives every pipeline register.

---
 rtl/pipe_ctrl_if.sv | 30 +++
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush request and per-stage control bundle for pipe_ctrl
interface pipe_ctrl_if;
    logic load_use;
    logic br_taken;
    logic mdu_start;
    logic mdu_done;
    logic dmem_ready;
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic ex_mem_flush;
    logic mem_wb_we;
    logic mdu_busy;
    logic mdu_timeout;

    modport master (
        input  load_use, br_taken, mdu_start, mdu_done, dmem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mem_wb_we, mdu_busy, mdu_timeout
    );

    modport slave (
        output load_use, br_taken, mdu_start, mdu_done, dmem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush,
               ex_mem_we, ex_mem_flush, mem_wb_we, mdu_busy, mdu_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline stall/flush sequencer with MDU watchdog
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush/MDU performance counters.
module pipe_ctrl #(
    parameter int MDU_MAX_CYC = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] mdu_cycles,
`endif
    pipe_ctrl_if.master      bus
);
    localparam int CW = $clog2(MDU_MAX_CYC + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_next_cnt;
    logic            r_timeout;
    logic            w_set_timeout;
    logic            w_frozen;
    logic            w_mdu_stall;

    assign w_frozen    = !bus.dmem_ready;
    assign w_mdu_stall = ((r_state == MDU_WAIT) && !bus.mdu_done) ||
                         ((r_state == RUN) && bus.mdu_start && !bus.mdu_done);

    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_wait_cnt;
        w_set_timeout = 1'b0;
        // Memory freeze holds the FSM and watchdog exactly where they are.
        if (!w_frozen) begin
            case (r_state)
                RUN: begin
                    if (bus.mdu_start && !bus.mdu_done) begin
                        w_next_state = MDU_WAIT;
                        w_next_cnt   = '0;
                    end
                end
                MDU_WAIT: begin
                    w_next_cnt = r_wait_cnt + CW'(1);
                    if (bus.mdu_done) begin
                        w_next_state = RUN;
                    end else if (r_wait_cnt == CW'(MDU_MAX_CYC - 1)) begin
                        w_next_state  = RUN;
                        w_set_timeout = 1'b1;
                    end
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_comb begin
        bus.pc_we        = 1'b1;
        bus.if_id_we     = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_we     = 1'b1;
        bus.id_ex_flush  = 1'b0;
        bus.ex_mem_we    = 1'b1;
        bus.ex_mem_flush = 1'b0;
        bus.mem_wb_we    = 1'b1;
        if (!rst) begin
            bus.pc_we        = 1'b0;
            bus.if_id_we     = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_we     = 1'b0;
            bus.id_ex_flush  = 1'b1;
            bus.ex_mem_we    = 1'b0;
            bus.ex_mem_flush = 1'b1;
            bus.mem_wb_we    = 1'b0;
        end else if (w_frozen) begin
            bus.pc_we     = 1'b0;
            bus.if_id_we  = 1'b0;
            bus.id_ex_we  = 1'b0;
            bus.ex_mem_we = 1'b0;
            bus.mem_wb_we = 1'b0;
        end else if (w_mdu_stall) begin
            bus.pc_we        = 1'b0;
            bus.if_id_we     = 1'b0;
            bus.id_ex_we     = 1'b0;
            bus.ex_mem_flush = 1'b1;
        end else if (bus.br_taken) begin
            // ID holds a wrong-path instruction, so a pending load-use is moot.
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (bus.load_use) begin
            bus.pc_we       = 1'b0;
            bus.if_id_we    = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    assign bus.mdu_busy    = rst && (r_state == MDU_WAIT);
    assign bus.mdu_timeout = r_timeout;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_cnt;
            r_timeout  <= r_timeout | w_set_timeout;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic [CNT_W-1:0] r_mdu_cycles;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
            r_mdu_cycles   <= '0;
        end else begin
            if (!bus.pc_we && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (bus.if_id_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + CNT_W'(1);
            if ((r_state == MDU_WAIT) && (r_mdu_cycles != '1))
                r_mdu_cycles <= r_mdu_cycles + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
    assign mdu_cycles   = r_mdu_cycles;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
    localparam int CNT_W = 16;

    // {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we}
    localparam logic [7:0] C_RST  = 8'b0010_1010;
    localparam logic [7:0] C_NORM = 8'b1101_0101;
    localparam logic [7:0] C_LU   = 8'b0001_1101;
    localparam logic [7:0] C_BR   = 8'b1111_1101;
    localparam logic [7:0] C_MDU  = 8'b0000_0111;
    localparam logic [7:0] C_FRZ  = 8'b0000_0000;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    pipe_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [CNT_W-1:0] mdu_cycles;
`endif

    pipe_ctrl #(
        .MDU_MAX_CYC (8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef PIPE_PERF_CNT_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .mdu_cycles   (mdu_cycles),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic lu, input logic br, input logic ms,
                        input logic md, input logic dr, input logic [7:0] ctrl,
                        input logic busy, input logic to, input string tag);
        logic [9:0] obs;
        logic [9:0] exp_v;
        string      t;
        @(negedge clk);
        rst            = r;
        bus.load_use   = lu;
        bus.br_taken   = br;
        bus.mdu_start  = ms;
        bus.mdu_done   = md;
        bus.dmem_ready = dr;
        exp_q.push_back({ctrl, busy, to});
        tag_q.push_back(tag);
        #1;
        obs = {bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_we, bus.id_ex_flush,
               bus.ex_mem_we, bus.ex_mem_flush, bus.mem_wb_we, bus.mdu_busy, bus.mdu_timeout};
        exp_v = exp_q.pop_front();
        t     = tag_q.pop_front();
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, obs, exp_v);
        end
    endtask

    task automatic check_cnt(input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp_v,
                             input string tag);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.load_use   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.mdu_start  = 1'b0;
        bus.mdu_done   = 1'b0;
        bus.dmem_ready = 1'b1;

        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 1, C_RST, 0, 0, "reset_hold");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "reset_release");

        step(1, 1, 0, 0, 0, 1, C_LU,   0, 0, "load_use");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "after_load_use");
`ifdef PIPE_PERF_CNT_EN
        check_cnt(stall_cycles, 1, "stall_cycles_lu");
`endif
        step(1, 1, 1, 0, 0, 1, C_BR,   0, 0, "branch_over_lu");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "after_branch");
`ifdef PIPE_PERF_CNT_EN
        check_cnt(flush_count, 1, "flush_count_br");
`endif

        step(1, 0, 0, 1, 0, 1, C_MDU, 0, 0, "mdu_start");
        for (int i = 0; i < 3; i++)
            step(1, 0, 0, 0, 0, 1, C_MDU, 1, 0, "mdu_wait");
        step(1, 0, 0, 0, 1, 1, C_NORM, 1, 0, "mdu_done");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "mdu_back_run");
`ifdef PIPE_PERF_CNT_EN
        check_cnt(mdu_cycles, 4, "mdu_cycles");
`endif

        step(1, 0, 0, 1, 0, 1, C_MDU, 0, 0, "frz_mdu_start");
        step(1, 0, 0, 0, 0, 1, C_MDU, 1, 0, "frz_mdu_wait");
        step(1, 0, 0, 0, 0, 0, C_FRZ, 1, 0, "mem_freeze_1");
        step(1, 0, 1, 0, 0, 0, C_FRZ, 1, 0, "mem_freeze_br");
        step(1, 0, 0, 0, 0, 1, C_MDU, 1, 0, "frz_mdu_resume");
        step(1, 0, 0, 0, 1, 1, C_NORM, 1, 0, "frz_mdu_done");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "frz_no_timeout");

        step(1, 0, 0, 1, 1, 1, C_NORM, 0, 0, "start_done_same");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "start_done_after");

        step(1, 0, 0, 1, 0, 1, C_MDU, 0, 0, "wd_start");
        for (int i = 0; i < 8; i++)
            step(1, 0, 0, 0, 0, 1, C_MDU, 1, 0, "wd_wait");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 1, "wd_timeout");
        step(1, 1, 0, 0, 0, 1, C_LU,   0, 1, "wd_sticky_lu");
        step(0, 0, 0, 0, 0, 1, C_RST,  0, 1, "wd_reset_edge");
        step(0, 0, 0, 0, 0, 1, C_RST,  0, 0, "wd_cleared");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "wd_release");

        step(1, 0, 0, 1, 0, 1, C_MDU,  0, 0, "midop_start");
        step(1, 0, 0, 0, 0, 1, C_MDU,  1, 0, "midop_wait");
        step(0, 0, 0, 0, 0, 1, C_RST,  0, 0, "midop_reset");
        step(1, 0, 0, 0, 0, 1, C_NORM, 0, 0, "midop_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
